// File: rtl/spi_fsm.sv
// Transaction sequencer for the SPI memory slave: address/RW capture, read-out and write-in
// sequencing, with registered Moore enables and the state code exported for the board LEDs.
module spi_fsm #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       rw_bit,
  output logic       addr_we,
  output logic       sr_we,
  output logic       dm_we,
  output logic       miso_en,
  output logic [3:0] state
);

  localparam int unsigned DLY_W = 2;

  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StGetAddr    = 4'd1,
    StGotAddr    = 4'd2,
    StReadMem    = 4'd3,
    StReadLoad   = 4'd4,
    StReadShift  = 4'd5,
    StWriteShift = 4'd6,
    StWriteMem   = 4'd7,
    StDone       = 4'd8
  } state_t;

  state_t             st_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [DLY_W-1:0]   dly_cnt_q;
  logic               cnt_full;

  // The counter only advances while below WIDTH, so it saturates and never wraps.
  assign cnt_full = (bit_cnt_q == CNT_W'(WIDTH));
  assign state    = st_q;

  // Enables are loaded alongside the state they belong to, so each one is a pure
  // decode of the registered state and comes straight out of a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= StIdle;
      bit_cnt_q <= '0;
      dly_cnt_q <= '0;
      addr_we   <= 1'b0;
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      miso_en   <= 1'b0;
    end else begin
      addr_we <= 1'b0;
      sr_we   <= 1'b0;
      dm_we   <= 1'b0;
      miso_en <= 1'b0;
      if (cs && st_q != StIdle) begin
        // Abort: cs wins over any coincident edge strobe.
        st_q      <= StIdle;
        bit_cnt_q <= '0;
        dly_cnt_q <= '0;
      end else begin
        case (st_q)
          StIdle: begin
            bit_cnt_q <= '0;
            if (!cs) st_q <= StGetAddr;
          end
          StGetAddr: begin
            if (cnt_full) begin
              st_q      <= StGotAddr;
              bit_cnt_q <= '0;
              addr_we   <= 1'b1;
            end else if (sclk_posedge) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          StGotAddr: begin
            if (rw_bit) begin
              st_q      <= StReadMem;
              dly_cnt_q <= DLY_W'(MEM_LAT);
            end else begin
              st_q <= StWriteShift;
            end
          end
          StReadMem: begin
            if (dly_cnt_q <= DLY_W'(1)) begin
              st_q      <= StReadLoad;
              dly_cnt_q <= '0;
              sr_we     <= 1'b1;
            end else begin
              dly_cnt_q <= dly_cnt_q - DLY_W'(1);
            end
          end
          StReadLoad: begin
            st_q    <= StReadShift;
            miso_en <= 1'b1;
          end
          StReadShift: begin
            if (cnt_full) begin
              st_q      <= StDone;
              bit_cnt_q <= '0;
            end else begin
              miso_en <= 1'b1;
              if (sclk_negedge) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          StWriteShift: begin
            if (cnt_full) begin
              st_q      <= StWriteMem;
              bit_cnt_q <= '0;
              dm_we     <= 1'b1;
            end else if (sclk_posedge) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          StWriteMem: st_q <= StDone;
          StDone:     st_q <= StDone;
          default: begin
            st_q      <= StIdle;
            bit_cnt_q <= '0;
            dly_cnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule
